// File: rtl/multi_pipe_monitor_pkg.sv
// Shared constants for the multi-channel pipe monitor: frame layout, status bits,
// FSM encoding and default thresholds.
package multi_pipe_monitor_pkg;
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam int ST_BIT_ALARM = 0;
  localparam int ST_BIT_SHUT  = 1;
  localparam int ST_BIT_HOT_A = 2;
  localparam int ST_BIT_HOT_S = 3;

  localparam int FLAG_OVERRUN = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam int DEF_ALARM_TH = 90;
  localparam int DEF_SHUT_TH  = 120;
  localparam int DEF_HYST     = 5;
  localparam int DEF_DEBOUNCE = 3;
endpackage

// File: rtl/multi_pipe_monitor_pipe_guard.sv
// Per-channel guard: debounced alarm with hysteresis and a latched shutdown that
// only releases on request once the pipe has cooled.
module pipe_guard
  import multi_pipe_monitor_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ALARM_TH = DEF_ALARM_TH,
  parameter int SHUT_TH  = DEF_SHUT_TH,
  parameter int HYST     = DEF_HYST,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] temp,
  input  logic              clear,
  output logic              alarm,
  output logic              shutdown,
  output logic [3:0]        status
);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DATA_W-1:0] A_SET = DATA_W'(ALARM_TH);
  localparam logic [DATA_W-1:0] A_CLR = DATA_W'(ALARM_TH - HYST);
  localparam logic [DATA_W-1:0] S_SET = DATA_W'(SHUT_TH);
  localparam logic [DATA_W-1:0] S_CLR = DATA_W'(SHUT_TH - HYST);
  localparam logic [CNT_W-1:0]  DB    = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0]  acnt, acnt_nxt, scnt, scnt_nxt;
  logic [DATA_W-1:0] last_temp;
  logic              hot_a, cool_a, hot_s, alarm_nxt, shut_nxt;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt);
    return (cnt == DB) ? cnt : cnt + CNT_W'(1);
  endfunction

  always_comb begin
    hot_a     = temp >= A_SET;
    cool_a    = temp <= A_CLR;
    hot_s     = temp >= S_SET;
    acnt_nxt  = '0;
    alarm_nxt = alarm;
    scnt_nxt  = '0;
    shut_nxt  = shutdown;
    if (hot_a) begin
      acnt_nxt = bump(acnt);
      if (acnt_nxt == DB) alarm_nxt = 1'b1;
    end else if (cool_a) begin
      alarm_nxt = 1'b0;
    end
    if (hot_s) begin
      scnt_nxt = bump(scnt);
      if (scnt_nxt == DB) shut_nxt = 1'b1;
    end
  end

  // An evaluation in the same cycle as a clear request takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      acnt      <= '0;
      scnt      <= '0;
      alarm     <= 1'b0;
      shutdown  <= 1'b0;
      last_temp <= '0;
      status    <= '0;
    end else if (enable) begin
      acnt      <= acnt_nxt;
      scnt      <= scnt_nxt;
      alarm     <= alarm_nxt;
      shutdown  <= shut_nxt;
      last_temp <= temp;
      status                 <= '0;
      status[ST_BIT_ALARM]   <= alarm_nxt;
      status[ST_BIT_SHUT]    <= shut_nxt;
      status[ST_BIT_HOT_A]   <= hot_a;
      status[ST_BIT_HOT_S]   <= hot_s;
    end else if (clear && last_temp < S_CLR) begin
      shutdown <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_pipe_monitor.sv
// Multi-channel pipe temperature monitor: snapshot, per-channel evaluation and a
// checksummed telemetry frame streamed over a valid/ready byte interface.
module multi_pipe_monitor
  import multi_pipe_monitor_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int ALARM_TH = DEF_ALARM_TH,
  parameter int SHUT_TH  = DEF_SHUT_TH,
  parameter int HYST     = DEF_HYST,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample,
  input  logic [CHANNELS*DATA_W-1:0] adc_bus,
  input  logic                       clear_shutdown,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [CHANNELS-1:0]        alarm,
  output logic [CHANNELS-1:0]        shutdown,
  output logic                       any_alarm,
  output logic                       any_shutdown,
  output logic                       busy,
  output logic                       overrun
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [5:0] LAST = 6'(2 + 2 * CHANNELS);

  if (CHANNELS < 1 || CHANNELS > 16 || DATA_W < 1 || DATA_W > 8 || DEBOUNCE < 1 ||
      SHUT_TH <= ALARM_TH || HYST > ALARM_TH || SHUT_TH >= (1 << DATA_W)) begin : g_bad_params
    $error("multi_pipe_monitor: inconsistent threshold/size parameters");
  end

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [5:0]        pos, nxt_pos, ch_off;
  logic [7:0]        csum, csum_nxt, nxt_byte;
  logic              ovr_sent, xfer, drop;
  logic [DATA_W-1:0] snap   [CHANNELS];
  logic [3:0]        status [CHANNELS];

  function automatic logic [7:0] zext(input logic [DATA_W-1:0] v);
    logic [7:0] r;
    r = '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pipe_guard #(
      .DATA_W(DATA_W), .ALARM_TH(ALARM_TH), .SHUT_TH(SHUT_TH),
      .HYST(HYST), .DEBOUNCE(DEBOUNCE)
    ) u_guard (
      .clk(clk),
      .reset(reset),
      .enable(state == ST_EVAL && idx == IDX_W'(k)),
      .temp(snap[k]),
      .clear(clear_shutdown),
      .alarm(alarm[k]),
      .shutdown(shutdown[k]),
      .status(status[k])
    );
  end

  assign busy = (state != ST_IDLE);
  assign xfer = tx_valid & tx_ready;
  assign drop = sample & busy;

  // Byte to present after the current one transfers; checksum folds in the outgoing byte.
  always_comb begin
    nxt_pos  = pos + 6'd1;
    ch_off   = nxt_pos - 6'd2;
    csum_nxt = (pos == 6'd0) ? csum : (csum ^ tx_data);
    nxt_byte = '0;
    if (nxt_pos == LAST) begin
      nxt_byte = csum_nxt;
    end else if (nxt_pos == 6'd1) begin
      nxt_byte[FLAG_OVERRUN] = overrun;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (ch_off[5:1] == 5'(k))
          nxt_byte = ch_off[0] ? {4'b0, status[k]} : zext(snap[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      pos          <= '0;
      csum         <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      overrun      <= 1'b0;
      ovr_sent     <= 1'b0;
      any_alarm    <= 1'b0;
      any_shutdown <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) snap[k] <= '0;
    end else begin
      any_alarm    <= |alarm;
      any_shutdown <= |shutdown;
      if (drop) overrun <= 1'b1;
      case (state)
        ST_IDLE: if (sample) begin
          for (int k = 0; k < CHANNELS; k++) snap[k] <= adc_bus[k*DATA_W +: DATA_W];
          idx   <= '0;
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(CHANNELS - 1)) begin
            state    <= ST_SEND;
            tx_valid <= 1'b1;
            tx_data  <= HEADER_BYTE;
            pos      <= '0;
            csum     <= '0;
          end
        end
        ST_SEND: if (xfer) begin
          if (pos == LAST) begin
            // Only the overrun already reported in this frame is retired.
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
            overrun  <= (overrun & ~ovr_sent) | drop;
          end else begin
            pos     <= nxt_pos;
            tx_data <= nxt_byte;
            csum    <= csum_nxt;
            if (nxt_pos == 6'd1) ovr_sent <= overrun;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_pipe_monitor.sv
// Directed bench for multi_pipe_monitor (4 channels, 8-bit samples, default thresholds).
module tb_multi_pipe_monitor;
  logic        clk = 1'b0;
  logic        reset, sample, clear_shutdown, tx_ready;
  logic [31:0] adc_bus;
  logic [7:0]  tx_data;
  logic        tx_valid, any_alarm, any_shutdown, busy, overrun;
  logic [3:0]  alarm, shutdown;

  int checks = 0;
  int failures = 0;
  logic [7:0] fr [0:15];
  int nb, lat, viol, stalls, seen;

  multi_pipe_monitor dut (
    .clk(clk), .reset(reset), .sample(sample), .adc_bus(adc_bus),
    .clear_shutdown(clear_shutdown), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .alarm(alarm), .shutdown(shutdown), .any_alarm(any_alarm),
    .any_shutdown(any_shutdown), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Pulse sample, wait for the header, then collect up to stop_after transferred bytes.
  task automatic scan(input string tag, input bit bp, input int pulse_at, input int stop_after);
    logic [7:0] held;
    bit stalled;
    int cyc;
    sample = 1'b1;
    step();
    sample = 1'b0;
    lat = 1;
    while (!tx_valid && lat < 60) begin
      step();
      lat++;
    end
    chk({tag, "_start"}, tx_valid, 1'b1);
    nb = 0; cyc = 0; viol = 0; stalls = 0;
    while (nb < stop_after && cyc < 400) begin
      if (bp) tx_ready = ((cyc / 3) % 2 == 0);
      sample = (cyc == pulse_at);
      if (tx_valid && tx_ready) begin
        fr[nb] = tx_data;
        nb++;
      end
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      step();
      cyc++;
      if (stalled) begin
        stalls++;
        if (tx_valid !== 1'b1 || tx_data !== held) viol++;
      end
    end
    sample = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input logic [87:0] exp);
    chk({tag, "_len"}, nb, 11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("%s_b%0d", tag, i), fr[i], exp[87-8*i -: 8]);
  endtask

  initial begin
    reset = 1'b1; sample = 1'b0; clear_shutdown = 1'b0; tx_ready = 1'b1; adc_bus = '0;
    step();
    step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_shutdown", shutdown, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_any", {any_alarm, any_shutdown}, 0);
    reset = 1'b0;
    step();

    // All-zero frame and latency
    scan("zero", 0, -1, 11);
    chk("zero_latency", lat, 5);
    chk_frame("zero", 88'hA5_00_00_00_00_00_00_00_00_00_00);
    chk("zero_busy_end", busy, 0);

    // Alarm debounce and hysteresis on channel 1
    adc_bus = {8'd0, 8'd0, 8'd95, 8'd0};
    scan("al1", 0, -1, 11);
    chk_frame("al1", 88'hA5_00_00_00_5F_04_00_00_00_00_5B);
    scan("al2", 0, -1, 11);
    chk_frame("al2", 88'hA5_00_00_00_5F_04_00_00_00_00_5B);
    chk("al2_alarm", alarm, 4'b0000);
    scan("al3", 0, -1, 11);
    chk_frame("al3", 88'hA5_00_00_00_5F_05_00_00_00_00_5A);
    chk("al3_alarm", alarm, 4'b0010);
    chk("al3_any_alarm", any_alarm, 1);
    adc_bus = {8'd0, 8'd0, 8'd88, 8'd0};
    scan("al4", 0, -1, 11);
    chk_frame("al4", 88'hA5_00_00_00_58_01_00_00_00_00_59);
    chk("al4_alarm", alarm, 4'b0010);
    adc_bus = {8'd0, 8'd0, 8'd85, 8'd0};
    scan("al5", 0, -1, 11);
    chk_frame("al5", 88'hA5_00_00_00_55_00_00_00_00_00_55);
    chk("al5_alarm", alarm, 4'b0000);

    // Shutdown latch and conditional clear on channel 2
    adc_bus = {8'd0, 8'd125, 8'd0, 8'd0};
    scan("sd1", 0, -1, 11);
    chk_frame("sd1", 88'hA5_00_00_00_00_00_7D_0C_00_00_71);
    scan("sd2", 0, -1, 11);
    chk("sd2_shutdown", shutdown, 4'b0000);
    scan("sd3", 0, -1, 11);
    chk_frame("sd3", 88'hA5_00_00_00_00_00_7D_0F_00_00_72);
    chk("sd3_shutdown", shutdown, 4'b0100);
    chk("sd3_any_shutdown", any_shutdown, 1);
    adc_bus = {8'd0, 8'd118, 8'd0, 8'd0};
    scan("sd4", 0, -1, 11);
    chk_frame("sd4", 88'hA5_00_00_00_00_00_76_07_00_00_71);
    clear_shutdown = 1'b1;
    step();
    clear_shutdown = 1'b0;
    chk("sd4_hot_clear", shutdown, 4'b0100);
    adc_bus = {8'd0, 8'd110, 8'd0, 8'd0};
    scan("sd5", 0, -1, 11);
    chk_frame("sd5", 88'hA5_00_00_00_00_00_6E_07_00_00_69);
    chk("sd5_before_clear", shutdown, 4'b0100);
    clear_shutdown = 1'b1;
    step();
    clear_shutdown = 1'b0;
    chk("sd5_cleared", shutdown, 4'b0000);
    step();
    chk("sd5_any_shutdown", any_shutdown, 0);

    // Backpressure with a sample dropped mid-frame
    do_reset();
    adc_bus = '0;
    step();
    scan("bp", 1, 12, 11);
    chk_frame("bp", 88'hA5_00_00_00_00_00_00_00_00_00_00);
    chk("bp_stall_seen", stalls > 0, 1);
    chk("bp_stall_stable", viol, 0);
    chk("bp_overrun", overrun, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) seen++;
      step();
    end
    chk("bp_no_extra_frame", seen, 0);
    chk("bp_idle", busy, 0);
    scan("ovr", 0, -1, 11);
    chk_frame("ovr", 88'hA5_01_00_00_00_00_00_00_00_00_01);
    chk("ovr_cleared", overrun, 0);

    // Checksum over distinct temperatures
    adc_bus = {8'd40, 8'd30, 8'd20, 8'd10};
    scan("cs1", 0, -1, 11);
    chk_frame("cs1", 88'hA5_00_0A_00_14_00_1E_00_28_00_28);
    adc_bus = {8'd40, 8'd30, 8'd20, 8'h0B};
    scan("cs2", 0, -1, 11);
    chk_frame("cs2", 88'hA5_00_0B_00_14_00_1E_00_28_00_29);

    // Reset in the middle of a frame
    adc_bus = {8'd0, 8'd0, 8'd0, 8'd95};
    scan("mr1", 0, -1, 11);
    scan("mr2", 0, -1, 11);
    scan("mr3", 0, -1, 11);
    chk("mr_alarm_set", alarm, 4'b0001);
    scan("mr4", 0, -1, 4);
    chk("mr4_partial_len", nb, 4);
    chk("mr4_still_valid", tx_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_tx_valid", tx_valid, 0);
    chk("mr_alarm", alarm, 0);
    chk("mr_busy", busy, 0);
    chk("mr_flags", {any_alarm, any_shutdown, overrun}, 0);
    adc_bus = '0;
    step();
    scan("mr5", 0, -1, 11);
    chk_frame("mr5", 88'hA5_00_00_00_00_00_00_00_00_00_00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
